// File: rtl/ALU593_pkg.sv
// Shared types for the ALU593 block and its command driver.
package ALU593_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    no_op1 = 3'b111
  } operation_t;

  typedef struct packed {
    operation_t  op;
    logic [7:0]  a;
    logic [7:0]  b;
  } cmd_t;

  typedef struct packed {
    operation_t  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] result;
    logic        timeout;
  } rsp_t;

  localparam logic [15:0] DRV_TIMEOUT_RESULT = 16'hDEAD;

  // Opcodes that never reach the ALU; the driver answers them itself.
  function automatic logic is_nop(input operation_t op);
    return (op == no_op) || (op == no_op1);
  endfunction

endpackage

// File: rtl/alu593_cmd_fifo.sv
// Command FIFO for the ALU593 driver; DEPTH must be a power of two so pointers wrap for free.
module alu593_cmd_fifo
  import ALU593_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  cmd_t                     wdata,
  input  logic                     pop,
  output cmd_t                     rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/alu593_cmd_driver.sv
// Issues buffered commands to ALU593 one at a time and returns {op,A,B,result} responses.
// Optional WAIT abort timer is built when ALU593_DRV_TIMEOUT_EN is defined.
module alu593_cmd_driver
  import ALU593_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  operation_t  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        start,
  output operation_t  op_set,
  output logic [7:0]  A,
  output logic [7:0]  B,
  input  logic        done,
  input  logic [15:0] result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output operation_t  rsp_op,
  output logic [7:0]  rsp_a,
  output logic [7:0]  rsp_b,
  output logic [15:0] rsp_result,
  output logic        rsp_timeout,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StGap} state_t;

  state_t                 state_q, state_d;
  logic                   start_q, start_d;
  rsp_t                   rsp_q, rsp_d;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  cmd_t                   fifo_head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   tmo_hit;
  logic                   issuing;

  alu593_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid & cmd_ready),
    .wdata ('{op: cmd_op, a: cmd_a, b: cmd_b}),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef ALU593_DRV_TIMEOUT_EN
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYC - 1);
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  tmo_cnt_q <= '0;
    else if (state_q == StIssue) tmo_cnt_q <= '0;
    else if (state_q == StWait)  tmo_cnt_q <= tmo_cnt_q + 16'd1;
  end

  assign tmo_hit = (state_q == StWait) && (tmo_cnt_q == TmoLast);
`else
  // TIMEOUT_CYC only matters when the abort timer is built.
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign tmo_hit            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    rsp_d   = rsp_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          rsp_d   = '{op: fifo_head.op, a: fifo_head.a, b: fifo_head.b,
                      result: 16'h0000, timeout: 1'b0};
          state_d = is_nop(fifo_head.op) ? StResp : StIssue;
        end
      end
      StIssue: begin
        start_d = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        // done beats a coincident timeout.
        if (done) begin
          rsp_d.result = result;
          start_d      = 1'b0;
          state_d      = StResp;
        end else if (tmo_hit) begin
          rsp_d.result  = DRV_TIMEOUT_RESULT;
          rsp_d.timeout = 1'b1;
          start_d       = 1'b0;
          state_d       = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StGap;
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      rsp_q   <= rsp_d;
    end
  end

  assign issuing     = (state_q == StIssue) || (state_q == StWait);
  assign start       = start_q;
  assign op_set      = issuing ? rsp_q.op : no_op;
  assign A           = issuing ? rsp_q.a : 8'h00;
  assign B           = issuing ? rsp_q.b : 8'h00;
  assign cmd_ready   = ~fifo_full;
  assign rsp_valid   = (state_q == StResp);
  assign rsp_op      = rsp_q.op;
  assign rsp_a       = rsp_q.a;
  assign rsp_b       = rsp_q.b;
  assign rsp_result  = rsp_q.result;
  assign rsp_timeout = rsp_q.timeout;
  assign busy        = (fifo_count != '0) || (state_q != StIdle);

endmodule
